// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM state
// encoding and a constant-evaluable ceil(log2) helper for counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fa_slice.sv
// Single-bit full adder; chained by serial_adder_hs into a ripple slice.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_hs.sv
// Serial adder/subtractor: BITS_PER_CYCLE full-adder slices reused over
// WIDTH/BITS_PER_CYCLE clocks, LSB first, with valid/ready on both sides.
module serial_adder_hs
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? clog2(N) : 1;

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
        $error("serial_adder_hs: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    state_t state, state_next;

    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          sum_sh;
    logic [WIDTH-1:0]          sum_next;
    logic [WIDTH-1:0]          sum_q;
    logic                      carry;
    logic                      cout_q;
    logic                      ovf_q;
    logic [CNT_W-1:0]          cnt;
    logic                      last_chunk;
    logic [BITS_PER_CYCLE:0]   c;
    logic [BITS_PER_CYCLE-1:0] s_chunk;

    assign c[0] = carry;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
        fa_slice u_fa (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .ci (c[i]),
            .s  (s_chunk[i]),
            .co (c[i+1])
        );
    end

    // New chunk enters at the MSB side; after N chunks the LSB chunk has
    // migrated down to bit 0.
    if (BITS_PER_CYCLE == WIDTH) begin : g_sum_full
        assign sum_next = s_chunk;
    end else begin : g_sum_shift
        assign sum_next = {s_chunk, sum_sh[WIDTH-1:BITS_PER_CYCLE]};
    end

    assign last_chunk = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> BITS_PER_CYCLE;
                    b_sh   <= b_sh >> BITS_PER_CYCLE;
                    sum_sh <= sum_next;
                    carry  <= c[BITS_PER_CYCLE];
                    cnt    <= cnt + CNT_W'(1);
                    // Visible outputs only change on the final chunk so they
                    // hold their previous result throughout IDLE and RUN.
                    if (last_chunk) begin
                        sum_q  <= sum_next;
                        cout_q <= c[BITS_PER_CYCLE];
                        ovf_q  <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                if (last_chunk) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_hs.sv
// Bench for serial_adder_hs: two instances (8-bit, 1 and 4 bits per cycle)
// checked against a vector table, an arithmetic reference model and corner sequences.
module tb_serial_adder_hs;

    logic       clk;
    logic       rst_n     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a         [2];
    logic [7:0] b         [2];
    logic       cin       [2];
    logic       sub       [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] sum       [2];
    logic       cout      [2];
    logic       overflow  [2];

    int checks   = 0;
    int failures = 0;

    serial_adder_hs #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0]), .overflow(overflow[0])
    );

    serial_adder_hs #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                  input logic ci, input logic sb,
                                  output logic [7:0] s, output logic co, output logic ov);
        int ux, uy, sx, sy, u, sv;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            u  = ux - uy + 256;
            sv = sx - sy;
        end else begin
            u  = ux + uy + int'(ci);
            sv = sx + sy + int'(ci);
        end
        s  = u[7:0];
        co = u[8];
        ov = (sv > 127) || (sv < -128);
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    task automatic txn(input int d, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts,
                       input logic [7:0] es, input logic ec, input logic eo, input int hold);
        int  lat;
        bit  got;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
        a[d] = ta; b[d] = tb; cin[d] = tc; sub[d] = ts;
        in_valid[d]  = 1'b1;
        out_ready[d] = (hold == 0);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a[d] = 8'($urandom); b[d] = 8'($urandom);
        cin[d] = 1'($urandom); sub[d] = 1'($urandom);
        lat = 0;
        got = 0;
        while (!got && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid[d]) got = 1;
        end
        chk("latency", 32'(lat), 32'(lat_of(d)));
        chk("sum", 32'(sum[d]), 32'(es));
        chk("cout", 32'(cout[d]), 32'(ec));
        chk("overflow", 32'(overflow[d]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid[d] = 1'b1;
            a[d] = 8'($urandom); b[d] = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid[d]), 32'd1);
            chk("bp_in_ready", 32'(in_ready[d]), 32'd0);
            chk("bp_sum", 32'(sum[d]), 32'(es));
            chk("bp_flags", {30'd0, cout[d], overflow[d]}, {30'd0, ec, eo});
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_out_valid", 32'(out_valid[d]), 32'd0);
        chk("release_in_ready", 32'(in_ready[d]), 32'd1);
        chk("idle_sum_hold", 32'(sum[d]), 32'(es));
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, rs, ec, eo;
        int         hits[$];

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            a[d] = '0; b[d] = '0; cin[d] = 1'b0; sub[d] = 1'b0;
        end
        #22;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
            chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset_sum", 32'(sum[d]), 32'd0);
            chk("reset_flags", {30'd0, cout[d], overflow[d]}, 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < vecs.size(); i++)
                txn(d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].sum, vecs[i].cout, vecs[i].ovf, 0);

        // Backpressure: five stalled cycles with spurious in_valid pulses.
        txn(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5);
        repeat (12) begin
            @(posedge clk); #1;
            chk("no_spurious_accept", 32'(out_valid[0]), 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 30; i++) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                model(ra, rb, rc, rs, es, ec, eo);
                txn(d, ra, rb, rc, rs, es, ec, eo, int'($urandom_range(0, 3)));
            end

        // Mid-run reset: outputs clear asynchronously and no result appears.
        txn(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0);
        @(negedge clk);
        a[0] = 8'h11; b[0] = 8'h22; cin[0] = 1'b0; sub[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("async_rst_sum", 32'(sum[0]), 32'd0);
        chk("async_rst_flags", {30'd0, cout[0], overflow[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("aborted_no_result", 32'(out_valid[0]), 32'd0);
        end
        txn(0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 0);

        // Back-to-back on the 4-bit-per-cycle instance: one result per N+2 cycles.
        @(negedge clk);
        a[1] = 8'hF0; b[1] = 8'h10; cin[1] = 1'b0; sub[1] = 1'b0;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (out_valid[1]) begin
                hits.push_back(cyc);
                chk("b2b_sum", {23'd0, cout[1], sum[1]}, 32'h100);
            end
        end
        @(negedge clk);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        chk("b2b_count", 32'(hits.size()), 32'd10);
        if (hits.size() > 0) chk("b2b_first", 32'(hits[0]), 32'd3);
        for (int i = 1; i < hits.size(); i++)
            chk("b2b_gap", 32'(hits[i] - hits[i-1]), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
